// File: rtl/aes_round_ctrl.sv
// Sequencing FSM for an AES-128 encryption datapath: walks the stage blocks through
// the initial key addition, rounds 1-9 and the final round, guarded by a stall watchdog.
module aes_round_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic       start,
  output logic       subenable,
  input  logic       subdone,
  output logic       rowenable,
  input  logic       rowsdone,
  output logic       mixenable,
  input  logic       mixdone,
  output logic       keyenable,
  input  logic       keydone,
  output logic       addenable,
  input  logic       adddone,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SUB, S_ROWS, S_MIX, S_KEY, S_ADD, S_DONE, S_ERR
  } state_t;

  state_t     r_state;
  logic [3:0] r_round;
  logic       r_entered;
  logic [7:0] r_wdog;

  state_t w_next;
  logic   w_stage_done;
  logic   w_stage;

  assign w_stage = (r_state == S_SUB) || (r_state == S_ROWS) || (r_state == S_MIX) ||
                   (r_state == S_KEY) || (r_state == S_ADD);

  always_comb begin
    w_next       = r_state;
    w_stage_done = 1'b0;
    case (r_state)
      S_SUB: begin
        w_next       = S_ROWS;
        w_stage_done = subdone;
      end
      S_ROWS: begin
        // The final round has no mixcolumns step.
        w_next       = (r_round == 4'd10) ? S_KEY : S_MIX;
        w_stage_done = rowsdone;
      end
      S_MIX: begin
        w_next       = S_KEY;
        w_stage_done = mixdone;
      end
      S_KEY: begin
        w_next       = S_ADD;
        w_stage_done = keydone;
      end
      S_ADD: begin
        w_next       = (r_round == 4'd10) ? S_DONE : S_SUB;
        w_stage_done = adddone;
      end
      default: begin
        w_next       = r_state;
        w_stage_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_round   <= 4'd0;
      r_entered <= 1'b0;
      r_wdog    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Round 0 uses the raw key, so key expansion is skipped.
            r_state   <= S_ADD;
            r_round   <= 4'd0;
            r_entered <= 1'b0;
            r_wdog    <= 8'd0;
          end
        end
        S_SUB, S_ROWS, S_MIX, S_KEY, S_ADD: begin
          if (r_entered && w_stage_done) begin
            r_state   <= w_next;
            r_entered <= 1'b0;
            r_wdog    <= 8'd0;
            if ((r_state == S_ADD) && (r_round != 4'd10))
              r_round <= r_round + 4'd1;
          end else if (r_wdog == 8'(TIMEOUT)) begin
            r_state   <= S_ERR;
            r_entered <= 1'b0;
            r_wdog    <= 8'd0;
          end else begin
            r_entered <= 1'b1;
            r_wdog    <= r_wdog + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_round <= 4'd0;
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  assign subenable = (r_state == S_SUB);
  assign rowenable = (r_state == S_ROWS);
  assign mixenable = (r_state == S_MIX);
  assign keyenable = (r_state == S_KEY);
  assign addenable = (r_state == S_ADD);
  assign round     = r_round;
  assign busy      = w_stage;
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a stub of registered stage blocks with
// configurable delays and faults, and one task per scenario.
module tb_aes_round_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       subenable, subdone;
  logic       rowenable, rowsdone;
  logic       mixenable, mixdone;
  logic       keyenable, keydone;
  logic       addenable, adddone;
  logic [3:0] round;
  logic       busy, done, err;

  int tests;
  int fails;

  // stub controls
  int sub_delay;
  bit force_sub;
  bit hold_rows3;
  int subcnt;

  aes_round_ctrl #(.TIMEOUT(15)) dut (
    .int_osc  (clk),
    .reset    (reset),
    .start    (start),
    .subenable(subenable),
    .subdone  (subdone),
    .rowenable(rowenable),
    .rowsdone (rowsdone),
    .mixenable(mixenable),
    .mixdone  (mixdone),
    .keyenable(keyenable),
    .keydone  (keydone),
    .addenable(addenable),
    .adddone  (adddone),
    .round    (round),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stage-block stub: each done is registered one cycle after its enable
  always @(posedge clk) begin
    subcnt   <= subenable ? subcnt + 1 : 0;
    subdone  <= force_sub | (subenable && (subcnt + 1 >= sub_delay));
    rowsdone <= rowenable && !(hold_rows3 && round == 4'd3);
    mixdone  <= mixenable;
    keydone  <= keyenable;
    adddone  <= addenable;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_enc(input int limit, input int extra_start_at,
                         output int lat, output int mix_v, output int key_v,
                         output int add_v, output int sub_cyc, output int done_cyc,
                         output bit seq_ok, output bit mix_ok,
                         output int rows3_at, output int err_at);
    bit pm, pk, pa, pr;
    lat = -1; mix_v = 0; key_v = 0; add_v = 0; sub_cyc = 0; done_cyc = 0;
    seq_ok = 1'b1; mix_ok = 1'b1; rows3_at = -1; err_at = -1;
    pm = 0; pk = 0; pa = 0; pr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= limit; n++) begin
      if (n > 0) @(negedge clk);
      start = (n == extra_start_at);
      if (mixenable && !pm) begin
        mix_v++;
        if (round < 4'd1 || round > 4'd9) mix_ok = 1'b0;
      end
      if (keyenable && !pk) key_v++;
      if (addenable && !pa) begin
        if (round != add_v[3:0]) seq_ok = 1'b0;
        add_v++;
      end
      if (rowenable && !pr && round == 4'd3 && rows3_at < 0) rows3_at = n;
      if (subenable) sub_cyc++;
      pm = mixenable; pk = keyenable; pa = addenable; pr = rowenable;
      if (err) begin
        err_at = n;
        break;
      end
      if (done) begin
        done_cyc++;
        if (lat < 0) lat = n;
      end else if (lat >= 0) begin
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    do_reset();
    start = 1'b0;
    tests++;
    if ({subenable, rowenable, mixenable, keyenable, addenable, busy, done, err} !== 8'b0 ||
        round !== 4'd0) begin
      fails++;
      $display("FAIL reset_outputs: got en/busy/done/err=%b round=%0d, want 0 and 0",
               {subenable, rowenable, mixenable, keyenable, addenable, busy, done, err}, round);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    $display("[TB] single: latency=%0d mix=%0d key=%0d add=%0d", lat, mv, kv, av);
    tests++;
    if (lat !== 100) begin fails++; $display("FAIL single_latency: got %0d want 100", lat); end
    tests++;
    if (mv !== 9 || !mo) begin fails++; $display("FAIL single_mix_visits: got %0d ok=%0b want 9 ok=1", mv, mo); end
    tests++;
    if (kv !== 10) begin fails++; $display("FAIL single_key_visits: got %0d want 10", kv); end
    tests++;
    if (av !== 11 || !sq) begin fails++; $display("FAIL single_round_seq: add=%0d seq_ok=%0b want 11/1", av, sq); end
    tests++;
    if (dc !== 1) begin fails++; $display("FAIL single_done_width: got %0d want 1", dc); end
    tests++;
    if (sc !== 20) begin fails++; $display("FAIL single_sub_cycles: got %0d want 20", sc); end
    tests++;
    if (round !== 4'd0 || busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_idle_after: round=%0d busy=%b err=%b want 0/0/0", round, busy, err);
    end
  endtask

  task automatic test_start_busy();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    run_enc(400, 20, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    $display("[TB] start_busy: latency=%0d done_cycles=%0d", lat, dc);
    tests++;
    if (lat !== 100 || dc !== 1) begin
      fails++;
      $display("FAIL busy_start_ignored: latency=%0d done_cycles=%0d want 100/1", lat, dc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL busy_no_restart: busy=%b done=%b want 0/0", busy, done);
        break;
      end
    end
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    $display("[TB] second start: latency=%0d", lat);
    tests++;
    if (lat !== 100) begin fails++; $display("FAIL second_latency: got %0d want 100", lat); end
  endtask

  task automatic test_watchdog();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    hold_rows3 = 1'b1;
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    $display("[TB] watchdog: rows3_at=%0d err_at=%0d", r3, ea);
    tests++;
    if (r3 < 0 || ea - r3 !== 16) begin
      fails++;
      $display("FAIL wdog_timing: err-rows_entry=%0d (r3=%0d) want 16", ea - r3, r3);
    end
    tests++;
    if (ea !== 40) begin fails++; $display("FAIL wdog_abs: err_at=%0d want 40", ea); end
    tests++;
    if ({subenable, rowenable, mixenable, keyenable, addenable, busy, done} !== 7'b0 || lat !== -1) begin
      fails++;
      $display("FAIL wdog_outputs: en/busy/done=%b lat=%0d want 0/-1",
               {subenable, rowenable, mixenable, keyenable, addenable, busy, done}, lat);
    end
    hold_rows3 = 1'b0;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wdog_sticky: err=%b busy=%b want 1/0", err, busy);
    end
    do_reset();
    tests++;
    if ({subenable, rowenable, mixenable, keyenable, addenable, busy, done, err} !== 8'b0 ||
        round !== 4'd0) begin
      fails++;
      $display("FAIL wdog_reset_clear: flags=%b round=%0d want 0/0",
               {subenable, rowenable, mixenable, keyenable, addenable, busy, done, err}, round);
    end
  endtask

  task automatic test_reset_mid();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    bit found;
    bit saw_done;
    found = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (mixenable && round == 4'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!found) begin fails++; $display("FAIL mid_reach_r5mix: got not-found want found"); end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || round !== 4'd0 || done !== 1'b0 || mixenable !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_idle: busy=%b round=%0d done=%b mix=%b want 0/0/0/0",
               busy, round, done, mixenable);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin fails++; $display("FAIL mid_no_done: got activity want none"); end
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    $display("[TB] after mid reset: latency=%0d", lat);
    tests++;
    if (lat !== 100) begin fails++; $display("FAIL mid_rerun_latency: got %0d want 100", lat); end
  endtask

  task automatic test_slow_sub();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    sub_delay = 4;
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    sub_delay = 1;
    $display("[TB] slow_sub: latency=%0d sub_cycles=%0d err_at=%0d", lat, sc, ea);
    tests++;
    if (lat !== 130 || ea !== -1) begin
      fails++;
      $display("FAIL slow_latency: got %0d err_at=%0d want 130/-1", lat, ea);
    end
    tests++;
    if (sc !== 50 || !sq) begin fails++; $display("FAIL slow_sub_cycles: got %0d seq=%0b want 50/1", sc, sq); end
  endtask

  task automatic test_stale_sub();
    int lat, mv, kv, av, sc, dc, r3, ea;
    bit sq, mo;
    force_sub = 1'b1;
    do_reset();
    run_enc(400, -1, lat, mv, kv, av, sc, dc, sq, mo, r3, ea);
    force_sub = 1'b0;
    $display("[TB] stale_sub: latency=%0d sub_cycles=%0d", lat, sc);
    tests++;
    if (lat !== 100 || sc !== 20) begin
      fails++;
      $display("FAIL stale_sub: latency=%0d sub_cycles=%0d want 100/20", lat, sc);
    end
    tests++;
    if (!sq || mv !== 9 || kv !== 10) begin
      fails++;
      $display("FAIL stale_order: seq=%0b mix=%0d key=%0d want 1/9/10", sq, mv, kv);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sub_delay = 1;
    force_sub = 1'b0;
    hold_rows3 = 1'b0;
    subcnt = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_start_busy();
    test_watchdog();
    test_reset_mid();
    test_slow_sub();
    test_stale_sub();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencing controller for the AES-128 encryption datapath.
- Drives the enable/done handshakes of five stage blocks: subbytes, shiftrows, mixcolumns, key expansion and addroundkey.
- Steps through the initial key addition, rounds 1–9 and the final round (which has no mixcolumns).
- Flags completion, or a stalled stage via a watchdog.

Parameters:
- TIMEOUT, 15: maximum cycles a stage state may wait for its done before the controller enters ERR. Legal range 2..255.

Ports:
- int_osc  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin one encryption; sampled only in IDLE.
- subenable  out  1  enable for subbytes.
- subdone  in  1  subbytes done; registered, high the cycle after subenable is sampled.
- rowenable  out  1  enable for shiftrows.
- rowsdone  in  1  shiftrows done; same timing as subdone.
- mixenable  out  1  enable for mixcolumns.
- mixdone  in  1  mixcolumns done.
- keyenable  out  1  enable for key expansion of the current round key.
- keydone  in  1  key expansion done.
- addenable  out  1  enable for addroundkey.
- adddone  in  1  addroundkey done.
- round  out  4  current round number, 0..10.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  one-cycle pulse when the ciphertext is valid in the state register.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset:
  - Next edge: state=IDLE, round=0, all enables=0, busy=0, done=0, err=0, watchdog=0.
  - Reset has priority over every other input, including start on the same edge.
  - Reset mid-encryption abandons the operation with no done pulse.
- States: IDLE, SUB, ROWS, MIX, KEY, ADD, DONE, ERR.
- Enables are Moore outputs decoded from the state register: exactly one enable is high in each stage state (SUB→subenable, etc.); all enables are 0 in IDLE, DONE and ERR.
- IDLE:
  - start=1 → ADD with round=0. This is the initial AddRoundKey; KEY is skipped because round 0 uses the raw key.
  - start=0 → stay in IDLE.
- Transitions from a stage state are taken only on the edge where that stage's done=1 AND the state has already been occupied for at least one cycle (an entry flag).
  - A done that is high on the entry cycle (stale) is ignored.
  - Done inputs of other stages are ignored.
- Stage order:
  - SUB→ROWS.
  - ROWS→MIX if round<10; ROWS→KEY if round=10.
  - MIX→KEY.
  - KEY→ADD.
  - ADD: if round<10, then round<=round+1 and go to SUB; if round=10, go to DONE and round holds at 10.
- DONE: done=1 for exactly one cycle, then IDLE with round<=0. start during DONE is ignored.
- start while busy has no effect. A new encryption requires start in IDLE.
- Latency with 1-cycle stage blocks:
  - Each stage occupies 2 cycles; 50 stage visits = 100 cycles.
  - start sampled at edge E → DONE state entered at edge E+100; done high for the cycle E+100..E+101; IDLE at E+101.
  - Slower stages extend their own state only.
- Watchdog:
  - Counter cleared on every state change, incremented each cycle in a stage state.
  - If it reaches TIMEOUT while still waiting, the next edge enters ERR.
  - ERR: err=1, busy=0, all enables 0; held until reset.
  - A done arriving on the same edge as the timeout wins (normal transition, no error).
- round never exceeds 10. round must be stable while keyenable is high, since the key block uses it to pick Rcon.

Test Plan:
- Bench stub returns each done registered one cycle after its enable. Reset, then start=1 for 1 cycle → done pulses exactly 100 cycles after the start edge; round sequence 0,1..10; mixenable seen in rounds 1–9 only (9 visits); keyenable 10 visits; addenable 11 visits.
- Pulse start on cycle 20 of an encryption → no effect; done occurs once at start0+100, and a second start in IDLE yields a second done 100 cycles later.
- Stub holds rowsdone low in round 3 → err=1 at edge ROWS-entry+TIMEOUT+1 (16 with the default); enables 0; busy 0; err stays 1 until reset, then all outputs return to reset values.
- Reset asserted in round 5 MIX together with start=1 → next edge IDLE, round=0, no done; a subsequent start completes normally in 100 cycles.
- Stub delays subdone by 4 cycles in every round → total latency = 100 + 3×10 = 130 cycles; no err.
- Force subdone=1 continuously from reset → SUB is still held 2 cycles per visit (the stale done on the entry cycle is ignored); ordering is unchanged.
